// File: rtl/dbus_arbiter.sv
// dbus_arbiter: owns the shared external data bus and grants each transfer slot
// to the CPU data port, the DMAC or an external bus master (BREQ_N/BACK_N).
// Grants move only at transfer boundaries and never inside a locked sequence.
// Build macro DBUS_ARB_RR_EN: round-robin CPU/DMA arbitration (burst limiter unused).
// Without it: fixed DMA > CPU priority plus a DMA burst limiter.
module dbus_arbiter #(
    parameter int unsigned HOFF_CYC      = 2,
    parameter int unsigned MAX_DMA_BURST = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ce_r_i,
    input  logic       ce_f_i,
    input  logic       cpu_req_i,
    input  logic       cpu_lock_i,
    input  logic       dma_req_i,
    input  logic       dma_lock_i,
    input  logic       bus_wait_i,
    input  logic       breq_n_i,
    output logic       back_n_o,
    output logic       cpu_gnt_o,
    output logic       dma_gnt_o,
    output logic [1:0] owner_o,
    output logic       bus_idle_o
);

    typedef enum logic [2:0] {IDLE, CPU, DMA, HOFF_IN, EXT, HOFF_OUT} state_t;

    localparam logic [3:0] HoffLoad = 4'(HOFF_CYC - 1);

    state_t     state_q, state_d, arbState;
    logic [3:0] hcnt_q, hcnt_d;
    logic       done_q;
    logic       sync1_q, sync2_q;
    logic       brq;
    logic       ownReq, ownLock;
    logic       freePoint, doneSample, pickDma;
    logic       cpuGnt_q, dmaGnt_q, backN_q, busIdle_q;
    logic [1:0] owner_q;

    assign brq = ~sync2_q;

    // Request and lock of whoever currently holds the bus
    always_comb begin
        ownReq  = 1'b0;
        ownLock = 1'b0;
        case (state_q)
            CPU: begin
                ownReq  = cpu_req_i;
                ownLock = cpu_lock_i;
            end
            DMA: begin
                ownReq  = dma_req_i;
                ownLock = dma_lock_i;
            end
            default: ;
        endcase
    end

    assign doneSample = ownReq & ~bus_wait_i;
    assign freePoint  = (done_q | ~ownReq) & ~ownLock & ~bus_wait_i;

`ifdef DBUS_ARB_RR_EN
    logic lastDma_q;

    // On a tie, the requester that did not own the bus last time wins
    assign pickDma = dma_req_i & (~cpu_req_i | ~lastDma_q);

    // Remember which of CPU/DMA was granted most recently
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lastDma_q <= 1'b0;
        end else if (ce_r_i) begin
            if (state_d == DMA) begin
                lastDma_q <= 1'b1;
            end else if (state_d == CPU) begin
                lastDma_q <= 1'b0;
            end
        end
    end
`else
    logic [3:0] bcnt_q, bcntInc;
    logic       limitHit;

    // Burst count including the transfer completing at this edge, saturating at 15
    always_comb begin
        bcntInc = bcnt_q;
        if (state_q == DMA && done_q && bcnt_q != 4'hF) begin
            bcntInc = bcnt_q + 4'd1;
        end
    end

    assign limitHit = (MAX_DMA_BURST != 0) && ({28'd0, bcntInc} >= MAX_DMA_BURST);
    assign pickDma  = dma_req_i & ~(state_q == DMA && limitHit && cpu_req_i);

    // Count consecutive DMA transfers; any CPU or external grant restarts the count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bcnt_q <= 4'd0;
        end else if (ce_r_i) begin
            if (state_d == CPU || state_d == HOFF_IN) begin
                bcnt_q <= 4'd0;
            end else begin
                bcnt_q <= bcntInc;
            end
        end
    end
`endif

    // Winner at an arbitration point: external master, then DMA, then CPU
    always_comb begin
        arbState = IDLE;
        if (brq) begin
            arbState = HOFF_IN;
        end else if (pickDma) begin
            arbState = DMA;
        end else if (cpu_req_i) begin
            arbState = CPU;
        end
    end

    // Next state and handoff counter, evaluated on rising-phase enables only
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (ce_r_i) begin
            case (state_q)
                IDLE: state_d = arbState;
                CPU, DMA: begin
                    if (freePoint) begin
                        state_d = arbState;
                    end
                end
                HOFF_IN: begin
                    if (hcnt_q == 4'd0) begin
                        state_d = EXT;
                    end else begin
                        hcnt_d = hcnt_q - 4'd1;
                    end
                end
                EXT: begin
                    if (!brq) begin
                        state_d = HOFF_OUT;
                    end
                end
                HOFF_OUT: begin
                    if (hcnt_q == 4'd0) begin
                        state_d = arbState;
                    end else begin
                        hcnt_d = hcnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d != state_q && (state_d == HOFF_IN || state_d == HOFF_OUT)) begin
            hcnt_d = HoffLoad;
        end
    end

    // State register and handoff counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            hcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Two-flop synchronizer for the asynchronous external bus request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else if (ce_r_i) begin
            sync1_q <= breq_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Transfer completion seen on the falling phase, held until the next rising phase
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_q <= 1'b0;
        end else if (ce_r_i) begin
            done_q <= 1'b0;
        end else if (ce_f_i && doneSample) begin
            done_q <= 1'b1;
        end
    end

    // Registered grant outputs decoded from the next state so they never glitch
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpuGnt_q  <= 1'b0;
            dmaGnt_q  <= 1'b0;
            backN_q   <= 1'b1;
            owner_q   <= 2'd0;
            busIdle_q <= 1'b1;
        end else begin
            cpuGnt_q  <= (state_d == CPU);
            dmaGnt_q  <= (state_d == DMA);
            backN_q   <= (state_d != EXT);
            busIdle_q <= (state_d == IDLE);
            case (state_d)
                CPU:     owner_q <= 2'd1;
                DMA:     owner_q <= 2'd2;
                EXT:     owner_q <= 2'd3;
                default: owner_q <= 2'd0;
            endcase
        end
    end

    assign cpu_gnt_o  = cpuGnt_q;
    assign dma_gnt_o  = dmaGnt_q;
    assign back_n_o   = backN_q;
    assign owner_o    = owner_q;
    assign bus_idle_o = busIdle_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed and randomized checks of dbus_arbiter against a
// slot-level behavioural model (one slot = one CE_R clock then one CE_F clock).
module tb_dbus_arbiter;

    localparam int HoffCyc  = 2;
    localparam int MaxBurst = 8;

    localparam int M_IDLE = 0;
    localparam int M_CPU  = 1;
    localparam int M_DMA  = 2;
    localparam int M_EXT  = 3;
    localparam int M_HIN  = 4;
    localparam int M_HOUT = 5;

    logic       clk, rstN, ceR, ceF;
    logic       cpuReq, cpuLock, dmaReq, dmaLock, busWait, breqN;
    logic       backN, cpuGnt, dmaGnt, busIdle;
    logic [1:0] owner;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state
    int mState;
    int mDeadLeft;
    int mBurst;
    bit mSync0, mSync1;
    bit mDone;

    dbus_arbiter #(
        .HOFF_CYC     (HoffCyc),
        .MAX_DMA_BURST(MaxBurst)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rstN),
        .ce_r_i    (ceR),
        .ce_f_i    (ceF),
        .cpu_req_i (cpuReq),
        .cpu_lock_i(cpuLock),
        .dma_req_i (dmaReq),
        .dma_lock_i(dmaLock),
        .bus_wait_i(busWait),
        .breq_n_i  (breqN),
        .back_n_o  (backN),
        .cpu_gnt_o (cpuGnt),
        .dma_gnt_o (dmaGnt),
        .owner_o   (owner),
        .bus_idle_o(busIdle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState    = M_IDLE;
        mDeadLeft = 0;
        mBurst    = 0;
        mSync0    = 1'b1;
        mSync1    = 1'b1;
        mDone     = 1'b0;
    endtask

    function automatic int modelPick(bit brq, bit fromDma, int burstNow);
        if (brq) return M_HIN;
        if (dmaReq && !(fromDma && MaxBurst != 0 && burstNow >= MaxBurst && cpuReq)) return M_DMA;
        if (cpuReq) return M_CPU;
        return M_IDLE;
    endfunction

    task automatic modelCeR();
        bit brq, ownReq, ownLock;
        int burstNow, nxt;
        brq      = !mSync1;
        ownReq   = (mState == M_CPU) ? cpuReq  : (mState == M_DMA) ? dmaReq  : 1'b0;
        ownLock  = (mState == M_CPU) ? cpuLock : (mState == M_DMA) ? dmaLock : 1'b0;
        burstNow = mBurst + ((mState == M_DMA && mDone) ? 1 : 0);
        nxt      = mState;
        case (mState)
            M_IDLE: nxt = modelPick(brq, 1'b0, burstNow);
            M_CPU, M_DMA: begin
                if ((mDone || !ownReq) && !ownLock && !busWait)
                    nxt = modelPick(brq, mState == M_DMA, burstNow);
            end
            M_HIN: begin
                mDeadLeft--;
                if (mDeadLeft == 0) nxt = M_EXT;
            end
            M_EXT: if (!brq) nxt = M_HOUT;
            default: begin
                mDeadLeft--;
                if (mDeadLeft == 0) nxt = modelPick(brq, 1'b0, burstNow);
            end
        endcase
        if ((nxt == M_HIN || nxt == M_HOUT) && nxt != mState) mDeadLeft = HoffCyc;
        mBurst = (nxt == M_CPU || nxt == M_HIN) ? 0 : burstNow;
        mState = nxt;
        mSync1 = mSync0;
        mSync0 = breqN;
        mDone  = 1'b0;
    endtask

    task automatic modelCeF();
        mDone = ((mState == M_CPU && cpuReq) || (mState == M_DMA && dmaReq)) && !busWait;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_cpu_gnt"},  cpuGnt,  mState == M_CPU);
        checkVal({tag, "_dma_gnt"},  dmaGnt,  mState == M_DMA);
        checkVal({tag, "_back_n"},   backN,   mState != M_EXT);
        checkVal({tag, "_bus_idle"}, busIdle, mState == M_IDLE);
        checkVal({tag, "_owner"},    owner,   (mState <= M_EXT) ? 2'(mState) : 2'd0);
    endtask

    // One slot: rising-phase enable on the first clock, falling-phase on the second
    task automatic runSlot();
        ceR = 1'b1;
        ceF = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ceR = 1'b0;
        ceF = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ceF = 1'b0;
    endtask

    task automatic applyStimulus(input logic cr, input logic cl, input logic dr, input logic dl,
                                 input logic bw, input logic bn, input string tag);
        cpuReq  = cr;
        cpuLock = cl;
        dmaReq  = dr;
        dmaLock = dl;
        busWait = bw;
        breqN   = bn;
        modelCeR();
        modelCeF();
        runSlot();
        checkOutput(tag);
    endtask

    task automatic asyncResetPulse(input string tag);
        #2 rstN = 1'b0;
        #1;
        checkVal({tag, "_cpu_gnt"},  cpuGnt,  1'b0);
        checkVal({tag, "_dma_gnt"},  dmaGnt,  1'b0);
        checkVal({tag, "_back_n"},   backN,   1'b1);
        checkVal({tag, "_bus_idle"}, busIdle, 1'b1);
        checkVal({tag, "_owner"},    owner,   2'd0);
        @(negedge clk);
        rstN = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput({tag, "_after"});
    endtask

    initial begin
        logic rBreq;
        rstN    = 1'b0;
        ceR     = 1'b0;
        ceF     = 1'b0;
        cpuReq  = 1'b0;
        cpuLock = 1'b0;
        dmaReq  = 1'b0;
        dmaLock = 1'b0;
        busWait = 1'b0;
        breqN   = 1'b1;
        modelReset();
        $display("[TB] dbus_arbiter bench starting");
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rstN = 1'b1;
        @(negedge clk);

        // CPU alone is granted on the first rising-phase enable
        applyStimulus(1, 0, 0, 0, 0, 1, "t1");
        checkVal("t1_cpu_gnt", cpuGnt, 1'b1);
        checkVal("t1_owner",   owner,  2'd1);
        checkVal("t1_back_n",  backN,  1'b1);

        // Both requesting: 8 DMA transfers then one CPU transfer, repeating
        applyStimulus(0, 0, 0, 0, 0, 1, "t2_idle");
        for (int s = 1; s <= 18; s++) begin
            applyStimulus(1, 0, 1, 0, 0, 1, "t2");
            checkVal("t2_dma_slot", dmaGnt, (s % 9) != 0);
            checkVal("t2_cpu_slot", cpuGnt, (s % 9) == 0);
        end

        // Locked DMA holds the bus against CPU and external master, then hands off
        applyStimulus(1, 0, 1, 0, 0, 1, "t3_dma");
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1, 0, 1, 1, 0, 0, "t3_lock");
            checkVal("t3_lock_dma_gnt", dmaGnt, 1'b1);
        end
        repeat (4) applyStimulus(1, 0, 1, 0, 0, 0, "t3_hoff");
        checkVal("t3_owner_ext", owner, 2'd3);
        checkVal("t3_back_n",    backN, 1'b0);

        // External master releases; pending CPU request follows the dead time
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 1, "t5_release");
        checkVal("t5_cpu_gnt", cpuGnt, 1'b1);
        checkVal("t5_owner",   owner,  2'd1);

        // External request while CPU transfer is stalled by BUS_WAIT
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, 0, 0, 0, 1, 0, "t4_wait");
            checkVal("t4_wait_cpu_gnt", cpuGnt, 1'b1);
        end
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, "t4_hoff");
        checkVal("t4_owner_ext", owner, 2'd3);
        checkVal("t4_back_n",    backN, 1'b0);

        // Back to CPU; CPU drops request while BUS_WAIT holds the grant, then async reset
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 1, "t6_cpu");
        applyStimulus(1, 0, 0, 0, 1, 1, "t6_wait");
        for (int s = 0; s < 2; s++) begin
            applyStimulus(0, 0, 1, 0, 1, 1, "t6_drop");
            checkVal("t6_drop_cpu_gnt", cpuGnt, 1'b1);
        end
        asyncResetPulse("t6_rst");

        // External request withdrawn during handoff-in
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, "t7_req");
        repeat (8) applyStimulus(0, 0, 0, 0, 0, 1, "t7_withdraw");

        // Randomized traffic against the model
        rBreq = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) rBreq = ~rBreq;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0, rBreq, "rnd");
            if (i == 200) asyncResetPulse("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
